// File: rtl/alu_packet_rx.sv
// Deframes the UART RX byte stream into little-endian ALU operand words or an
// ECHO pass-through stream, and flags unknown opcodes and malformed lengths.
module alu_packet_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] m_word_tdata,
  output logic                             m_word_tvalid,
  input  logic                             m_word_tready,
  output logic                             m_word_tlast,
  output logic [7:0]                       m_word_op,
  output logic [DATA_WIDTH-1:0]            echo_tdata,
  output logic                             echo_tvalid,
  input  logic                             echo_tready,
  output logic                             echo_tlast,
  output logic                             err_o,
  output logic [1:0]                       err_code_o
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_DIV  = 8'h03;
  localparam logic [7:0] OP_ECHO = 8'hEC;

  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_LENGTH = 2'd2;

  typedef enum logic [2:0] {
    S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_WORD, S_WOUT, S_ECHO, S_DRAIN
  } state_t;

  state_t                          state_q, state_d;
  logic [7:0]                      op_q, op_d;
  logic [15:0]                     rem_q, rem_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [DATA_WIDTH*WORD_BYTES-1:0] word_q, word_d;
  logic                            err_q, err_d;
  logic [1:0]                      err_code_q, err_code_d;
  logic [15:0]                     len;
  logic [15:0]                     plen;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_OPCODE;
      op_q       <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no latch is inferred.
    state_d       = state_q;
    op_d          = op_q;
    rem_d         = rem_q;
    idx_d         = idx_q;
    word_d        = word_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    s_axis_tready = 1'b0;
    m_word_tvalid = 1'b0;
    m_word_tlast  = 1'b0;
    echo_tvalid   = 1'b0;
    echo_tlast    = 1'b0;
    len           = {s_axis_tdata, rem_q[7:0]};
    plen          = len - 16'd4;

    case (state_q)
      S_OPCODE: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tdata inside {OP_ADD, OP_MUL, OP_DIV, OP_ECHO}) begin
            op_d    = s_axis_tdata;
            state_d = S_RSVD;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_OPCODE;
          end
        end
      end
      S_RSVD: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          rem_d[7:0] = s_axis_tdata;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          rem_d = plen;
          idx_d = '0;
          if (len < 16'd4) begin
            err_d      = 1'b1;
            err_code_d = ERR_LENGTH;
            state_d    = S_OPCODE;
          end else if (op_q == OP_ECHO) begin
            state_d = (len == 16'd4) ? S_OPCODE : S_ECHO;
          end else if (plen == 16'd0 || (plen % 16'(WORD_BYTES)) != 16'd0) begin
            err_d      = 1'b1;
            err_code_d = ERR_LENGTH;
            state_d    = (len > 16'd4) ? S_DRAIN : S_OPCODE;
          end else if (op_q == OP_DIV && len != 16'd12) begin
            err_d      = 1'b1;
            err_code_d = ERR_LENGTH;
            state_d    = S_DRAIN;
          end else begin
            state_d = S_WORD;
          end
        end
      end
      S_WORD: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          word_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
          idx_d = idx_q + 1'b1;
          rem_d = rem_q - 16'd1;
          if (idx_q == IDX_W'(WORD_BYTES - 1)) state_d = S_WOUT;
        end
      end
      S_WOUT: begin
        m_word_tvalid = 1'b1;
        m_word_tlast  = (rem_q == 16'd0);
        if (m_word_tready) begin
          idx_d   = '0;
          state_d = (rem_q == 16'd0) ? S_OPCODE : S_WORD;
        end
      end
      S_ECHO: begin
        // Downstream backpressure flows straight through to the UART side.
        echo_tvalid   = s_axis_tvalid;
        s_axis_tready = echo_tready;
        echo_tlast    = (rem_q == 16'd1);
        if (s_axis_tvalid && echo_tready) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_OPCODE;
        end
      end
      S_DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_OPCODE;
        end
      end
      default: state_d = S_OPCODE;
    endcase
  end

  assign echo_tdata   = s_axis_tdata;
  assign m_word_tdata = word_q;
  assign m_word_op    = op_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_alu_packet_rx.sv
// Self-checking bench for alu_packet_rx: directed corner sequences, a header
// vector table and randomized packet streams scored against a packet-level model.
module tb_alu_packet_rx;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_word_tdata;
  logic        m_word_tvalid;
  logic        m_word_tready;
  logic        m_word_tlast;
  logic [7:0]  m_word_op;
  logic [7:0]  echo_tdata;
  logic        echo_tvalid;
  logic        echo_tready;
  logic        echo_tlast;
  logic        err_o;
  logic [1:0]  err_code_o;

  alu_packet_rx dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_word_tdata(m_word_tdata), .m_word_tvalid(m_word_tvalid), .m_word_tready(m_word_tready),
    .m_word_tlast(m_word_tlast), .m_word_op(m_word_op),
    .echo_tdata(echo_tdata), .echo_tvalid(echo_tvalid), .echo_tready(echo_tready),
    .echo_tlast(echo_tlast), .err_o(err_o), .err_code_o(err_code_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] data; logic last; logic [7:0] op; } word_t;
  typedef struct { logic [7:0] data; logic last; } echo_t;
  typedef struct { logic [7:0] op; int len; int err; int nwords; int necho; } hdr_vec_t;

  word_t      got_w[$], exp_w[$];
  echo_t      got_e[$], exp_e[$];
  logic [1:0] got_err[$], exp_err[$];
  logic [7:0] sent_q[$], pkt_q[$];

  int   pass_cnt = 0, total_cnt = 0;
  int   word_rdy_pct = 100, echo_rdy_pct = 100;
  int   bad_accept = 0, bad_hold = 0;
  logic prev_wait = 1'b0;
  logic [31:0] prev_data = '0;

  // Sink-side ready generators.
  initial forever begin
    @(negedge clk_i);
    m_word_tready = ($urandom_range(0, 99) < word_rdy_pct);
    echo_tready   = ($urandom_range(0, 99) < echo_rdy_pct);
  end

  // Output monitor: records transfers and watches the word handshake rules.
  initial forever begin
    @(negedge clk_i);
    #1;
    if (!reset_i) begin
      if (m_word_tvalid && s_axis_tready) bad_accept++;
      if (prev_wait && (!m_word_tvalid || m_word_tdata != prev_data)) bad_hold++;
      prev_wait = m_word_tvalid && !m_word_tready;
      prev_data = m_word_tdata;
      if (m_word_tvalid && m_word_tready) got_w.push_back('{m_word_tdata, m_word_tlast, m_word_op});
      if (echo_tvalid && echo_tready) got_e.push_back('{echo_tdata, echo_tlast});
      if (err_o) got_err.push_back(err_code_o);
    end else begin
      prev_wait = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic finish_tb();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_i);
      s_axis_tvalid = 1'b0;
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct, output int cycles);
    bit done = 1'b0;
    cycles = 0;
    while (!done) begin
      @(negedge clk_i);
      cycles++;
      if ($urandom_range(0, 99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'($urandom);
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
      end
      #1;
      if (s_axis_tvalid && s_axis_tready) done = 1'b1;
      else if (cycles > 300) begin
        check("byte_accept_timeout", 64'(s_axis_tready), 64'd1);
        finish_tb();
      end
    end
    sent_q.push_back(b);
  endtask

  task automatic send_pkt(input int gap_pct, output int cycles);
    int c;
    cycles = 0;
    foreach (pkt_q[k]) begin
      send_byte(pkt_q[k], gap_pct, c);
      cycles += c;
    end
    pkt_q.delete();
  endtask

  task automatic make_pkt(input logic [7:0] op, input int len);
    logic [15:0] l16;
    l16 = 16'(len);
    pkt_q.push_back(op);
    pkt_q.push_back(8'($urandom));
    pkt_q.push_back(l16[7:0]);
    pkt_q.push_back(l16[15:8]);
    for (int k = 4; k < len; k++) pkt_q.push_back(8'($urandom));
  endtask

  task automatic push_bytes(input logic [7:0] b0, b1, b2, b3);
    pkt_q.push_back(b0); pkt_q.push_back(b1); pkt_q.push_back(b2); pkt_q.push_back(b3);
  endtask

  // Packet-level reference: walks the accepted byte stream packet by packet.
  task automatic run_model();
    int i = 0;
    exp_w.delete(); exp_e.delete(); exp_err.delete();
    while (i < sent_q.size()) begin
      logic [7:0] op = sent_q[i];
      int len;
      if (!(op inside {8'h01, 8'h02, 8'h03, 8'hEC})) begin
        exp_err.push_back(2'd1);
        i++;
        continue;
      end
      if (i + 4 > sent_q.size()) break;
      len = int'({sent_q[i+3], sent_q[i+2]});
      if (len < 4) begin
        exp_err.push_back(2'd2);
        i += 4;
        continue;
      end
      if (op == 8'hEC) begin
        for (int k = 4; k < len; k++) exp_e.push_back('{sent_q[i+k], k == len - 1});
      end else if ((len - 4) == 0 || (len - 4) % 4 != 0 || (op == 8'h03 && len != 12)) begin
        exp_err.push_back(2'd2);
      end else begin
        for (int w = 0; w < (len - 4) / 4; w++) begin
          int b = i + 4 + 4 * w;
          exp_w.push_back('{{sent_q[b+3], sent_q[b+2], sent_q[b+1], sent_q[b]},
                            w == (len - 4) / 4 - 1, op});
        end
      end
      i += len;
    end
  endtask

  task automatic clear_all();
    got_w.delete(); got_e.delete(); got_err.delete(); sent_q.delete();
  endtask

  task automatic compare_all(input string tag);
    run_model();
    check({tag, "_nwords"}, 64'(got_w.size()), 64'(exp_w.size()));
    check({tag, "_necho"}, 64'(got_e.size()), 64'(exp_e.size()));
    check({tag, "_nerr"}, 64'(got_err.size()), 64'(exp_err.size()));
    for (int k = 0; k < got_w.size() && k < exp_w.size(); k++)
      check($sformatf("%s_word%0d", tag, k),
            64'({got_w[k].op, got_w[k].last, got_w[k].data}),
            64'({exp_w[k].op, exp_w[k].last, exp_w[k].data}));
    for (int k = 0; k < got_e.size() && k < exp_e.size(); k++)
      check($sformatf("%s_echo%0d", tag, k),
            64'({got_e[k].last, got_e[k].data}), 64'({exp_e[k].last, exp_e[k].data}));
    for (int k = 0; k < got_err.size() && k < exp_err.size(); k++)
      check($sformatf("%s_err%0d", tag, k), 64'(got_err[k]), 64'(exp_err[k]));
    clear_all();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    s_axis_tvalid = 1'b0;
    tick(2);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
  endtask

  task automatic check_idle(input string tag);
    check(tag, 64'({m_word_tvalid, m_word_tlast, echo_tvalid, echo_tlast, err_o, err_code_o, s_axis_tready}),
          64'(8'b0000_0001));
  endtask

  hdr_vec_t vecs[14];

  initial begin
    int cyc;
    logic [7:0] b;

    vecs[0]  = '{8'h01, 8,      0, 1, 0};
    vecs[1]  = '{8'h01, 4,      2, 0, 0};
    vecs[2]  = '{8'h01, 7,      2, 0, 0};
    vecs[3]  = '{8'h02, 10,     2, 0, 0};
    vecs[4]  = '{8'h03, 16,     2, 0, 0};
    vecs[5]  = '{8'h03, 12,     0, 2, 0};
    vecs[6]  = '{8'h03, 8,      2, 0, 0};
    vecs[7]  = '{8'hEC, 4,      0, 0, 0};
    vecs[8]  = '{8'hEC, 5,      0, 0, 1};
    vecs[9]  = '{8'h02, 2,      2, 0, 0};
    vecs[10] = '{8'hEC, 0,      2, 0, 0};
    vecs[11] = '{8'h02, 20,     0, 4, 0};
    vecs[12] = '{8'h01, 16'h0106, 2, 0, 0};
    vecs[13] = '{8'hEC, 16'h0104, 0, 0, 256};

    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check_idle("reset_state");

    // ADD with the word sink stalled for 10 cycles.
    word_rdy_pct = 0;
    push_bytes(8'h01, 8'h00, 8'h0C, 8'h00);
    push_bytes(8'h05, 8'h00, 8'h00, 8'h00);
    send_pkt(0, cyc);
    for (int c = 0; c < 10; c++) begin
      tick(1);
      check($sformatf("add_hold%0d", c),
            64'({m_word_tvalid, s_axis_tready, m_word_tlast, m_word_op, m_word_tdata}),
            64'({1'b1, 1'b0, 1'b0, 8'h01, 32'h5}));
    end
    word_rdy_pct = 100;
    push_bytes(8'h07, 8'h00, 8'h00, 8'h00);
    send_pkt(0, cyc);
    tick(4);
    compare_all("add");

    // ECHO with toggling downstream ready, then a following packet.
    echo_rdy_pct = 50;
    push_bytes(8'hEC, 8'h00, 8'h07, 8'h00);
    pkt_q.push_back(8'h41); pkt_q.push_back(8'h42); pkt_q.push_back(8'h43);
    push_bytes(8'h01, 8'h00, 8'h08, 8'h00);
    push_bytes(8'h11, 8'h22, 8'h33, 8'h44);
    send_pkt(30, cyc);
    tick(6);
    compare_all("echo");
    echo_rdy_pct = 100;

    // Unknown opcode then DIV.
    pkt_q.push_back(8'h55);
    push_bytes(8'h03, 8'h00, 8'h0C, 8'h00);
    push_bytes(8'h10, 8'h00, 8'h00, 8'h00);
    push_bytes(8'h03, 8'h00, 8'h00, 8'h00);
    send_pkt(10, cyc);
    tick(6);
    compare_all("div");

    // Bad MUL length drained, then OK packet; then len=2 with pulse timing.
    push_bytes(8'h02, 8'h00, 8'h0A, 8'h00);
    push_bytes(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    pkt_q.push_back(8'hA5); pkt_q.push_back(8'hA6);
    push_bytes(8'h01, 8'h00, 8'h08, 8'h00);
    push_bytes(8'h09, 8'h08, 8'h07, 8'h06);
    send_pkt(10, cyc);
    tick(4);
    push_bytes(8'h02, 8'h00, 8'h02, 8'h00);
    send_pkt(0, cyc);
    tick(1);
    check("len2_err_pulse", 64'({err_o, err_code_o, s_axis_tready}), 64'(4'b1101));
    tick(2);
    check("err_code_held", 64'({err_o, err_code_o}), 64'(3'b010));
    compare_all("mul_bad");

    // Reset in the middle of an ADD payload.
    push_bytes(8'h01, 8'h00, 8'h0C, 8'h00);
    pkt_q.push_back(8'h05); pkt_q.push_back(8'h00);
    send_pkt(0, cyc);
    do_reset();
    check_idle("midpkt_reset_state");
    tick(3);
    check("midpkt_no_word", 64'(got_w.size()), 64'd0);
    clear_all();
    push_bytes(8'h01, 8'h00, 8'h0C, 8'h00);
    push_bytes(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    push_bytes(8'h01, 8'h02, 8'h03, 8'h04);
    send_pkt(0, cyc);
    tick(4);
    compare_all("post_reset");

    // Back-to-back echo packets with continuous tvalid: one byte per cycle.
    push_bytes(8'hEC, 8'h00, 8'h04, 8'h00);
    push_bytes(8'hEC, 8'h00, 8'h06, 8'h00);
    pkt_q.push_back(8'hAA); pkt_q.push_back(8'hBB);
    push_bytes(8'hEC, 8'h00, 8'h04, 8'h00);
    send_pkt(0, cyc);
    check("b2b_no_bubble", 64'(cyc), 64'd14);
    tick(2);
    compare_all("b2b");

    // Header vector table.
    foreach (vecs[v]) begin
      make_pkt(vecs[v].op, vecs[v].len);
      send_pkt(20, cyc);
      tick(20);
      check($sformatf("vec%0d_nwords", v), 64'(got_w.size()), 64'(vecs[v].nwords));
      check($sformatf("vec%0d_necho", v), 64'(got_e.size()), 64'(vecs[v].necho));
      check($sformatf("vec%0d_errcode", v),
            64'((got_err.size() > 0) ? int'(got_err[0]) : 0), 64'(vecs[v].err));
      compare_all($sformatf("vec%0d", v));
    end

    // Randomized packet streams under varying backpressure.
    for (int r = 0; r < 4; r++) begin
      word_rdy_pct = int'($urandom_range(30, 100));
      echo_rdy_pct = int'($urandom_range(30, 100));
      for (int p = 0; p < 15; p++) begin
        case ($urandom_range(0, 6))
          0: make_pkt(8'h01, 4 + 4 * int'($urandom_range(1, 4)));
          1: make_pkt(8'h02, 4 + 4 * int'($urandom_range(1, 4)));
          2: make_pkt(8'h03, 12);
          3: make_pkt(8'hEC, int'($urandom_range(4, 12)));
          4: begin
            b = 8'($urandom);
            while (b inside {8'h01, 8'h02, 8'h03, 8'hEC}) b = 8'($urandom);
            pkt_q.push_back(b);
          end
          5: make_pkt(8'h03, 4 * int'($urandom_range(1, 5)));
          default: begin
            case ($urandom_range(0, 3))
              0: b = 8'h01;
              1: b = 8'h02;
              2: b = 8'h03;
              default: b = 8'hEC;
            endcase
            make_pkt(b, int'($urandom_range(0, 15)));
          end
        endcase
      end
      send_pkt(int'($urandom_range(0, 40)), cyc);
      word_rdy_pct = 100;
      tick(40);
      compare_all($sformatf("rand%0d", r));
    end

    check("no_accept_while_word", 64'(bad_accept), 64'd0);
    check("word_hold_stable", 64'(bad_hold), 64'd0);
    finish_tb();
  end

endmodule
